spi_slave_regif: RTL and testbench

Host-facing SPI slave front-end inside decred_top. It consumes the synchronised-in SCLK_fromHost / SCSN_fromHost / MOSI_fromHost pins, decodes byte-framed register transactions, and drives the miner register bank through a simple strobe interface. It also produces MISO_toHost read data. SCLK is oversampled in the SPI_CLK domain; SCLK is never used as a clock.

---
 rtl/spi_slave_regif.sv | 149 ++++++++++++++
 tb/tb_spi_slave_regif.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave front-end driving a byte-addressed register bank.
// The host pins are oversampled in the SPI_CLK domain, and SCLK is only ever treated as data.
// A frame is one command byte followed by a burst of data bytes:
//   command bit 7 = 1 selects write, 0 selects read;
//   command bits [6:0] give the start address, which auto-increments after each data byte.
module spi_slave_regif #(
    parameter int ADDR_WIDTH  = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  SPI_CLK,
    input  logic                  SPI_CLK_RESET_N,
    input  logic                  SCLK,
    input  logic                  SCSN,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  WR_STB,
    output logic [7:0]            WR_DATA,
    output logic                  RD_REQ,
    input  logic [7:0]            RD_DATA,
    output logic                  FRAME_ACTIVE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, scsn_sync, mosi_sync;
    logic                   sclk_q, scsn_q;
    logic                   sclk_s, scsn_s, mosi_s;
    logic                   sclk_rise, sclk_fall, scsn_rise, scsn_fall;
    logic                   active, byte_done;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_in, byte_in, tx_sr;
    logic                   rd_ld;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign scsn_s    = scsn_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign scsn_rise = scsn_s & ~scsn_q;
    assign scsn_fall = ~scsn_s & scsn_q;

    assign active       = (state != ST_IDLE);
    assign byte_in      = {shift_in[6:0], mosi_s};
    // A chip-select release in the same cycle as the 8th rise discards the byte.
    assign byte_done    = active && sclk_rise && (bit_cnt == 3'd7) && !scsn_rise;
    assign MISO         = tx_sr[7];
    assign MISO_OE      = active;
    assign FRAME_ACTIVE = active;

    // Synchronise the asynchronous host pins, then keep one history flop for edge detection.
    // The chains reset to the idle bus levels: SCLK low, SCSN high.
    always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
        if (!SPI_CLK_RESET_N) begin
            sclk_sync <= '0;
            scsn_sync <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            scsn_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop in the chain sample the old value of the stage before it, so each stage adds exactly one cycle.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            scsn_sync <= {scsn_sync[SYNC_STAGES-2:0], SCSN};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_q    <= sclk_s;
            scsn_q    <= scsn_s;
        end
    end

    // Frame state register.
    always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
        if (!SPI_CLK_RESET_N) state <= ST_IDLE;
        else                  state <= next_state;
    end

    // Next state: the command byte selects the write or read phase; releasing chip select always returns to idle.
    always_comb begin
        // NOTE: a default assigned first covers every path through the case, so no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE: if (scsn_fall) next_state = ST_CMD;
            ST_CMD:  if (byte_done) next_state = byte_in[7] ? ST_WDATA : ST_RDATA;
            default: ;
        endcase
        if (active && scsn_rise) next_state = ST_IDLE;
    end

    // Datapath: bit assembly, address and strobe generation, and the read shift register.
    always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
        if (!SPI_CLK_RESET_N) begin
            ADDR     <= '0;
            WR_STB   <= 1'b0;
            WR_DATA  <= '0;
            RD_REQ   <= 1'b0;
            rd_ld    <= 1'b0;
            bit_cnt  <= '0;
            shift_in <= '0;
            tx_sr    <= '0;
        end else begin
            WR_STB <= 1'b0;
            RD_REQ <= 1'b0;
            rd_ld  <= RD_REQ;
            // The address advances on the cycle after a write strobe, so WR_STB always sees the address it is writing.
            if (WR_STB) ADDR <= ADDR + ADDR_WIDTH'(1);
            if (!active || scsn_rise) begin
                // Outside a frame, or when a frame aborts, partial bytes and pending read loads are dropped and MISO returns low.
                bit_cnt <= '0;
                tx_sr   <= '0;
                rd_ld   <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    shift_in <= byte_in;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                // The fall that ends a byte (bit_cnt == 0) leaves the freshly loaded MSB on MISO for the next rise.
                if (sclk_fall && state == ST_RDATA && bit_cnt != 3'd0)
                    tx_sr <= {tx_sr[6:0], 1'b0};
                if (rd_ld && state == ST_RDATA)
                    tx_sr <= RD_DATA;
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            ADDR   <= byte_in[ADDR_WIDTH-1:0];
                            RD_REQ <= ~byte_in[7];
                        end
                        ST_WDATA: begin
                            WR_DATA <= byte_in;
                            WR_STB  <= 1'b1;
                        end
                        ST_RDATA: begin
                            ADDR   <= ADDR + ADDR_WIDTH'(1);
                            RD_REQ <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Self-checking bench for spi_slave_regif.
// The bench acts as the SPI host at the minimum SCLK high/low time.
// A register model answers reads combinationally from ADDR.
// Every strobe is logged, and each frame is compared against the expected transaction list.
module tb_spi_slave_regif;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = SYNC_STAGES + 2;

    logic       SPI_CLK = 1'b0;
    logic       SPI_CLK_RESET_N;
    logic       SCLK, SCSN, MOSI;
    logic       MISO, MISO_OE, WR_STB, RD_REQ, FRAME_ACTIVE;
    logic [6:0] ADDR;
    logic [7:0] WR_DATA, RD_DATA;

    logic [7:0]  rd_mem [128];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [14:0] wr_log [$];
    logic [6:0]  rd_log [$];
    int          excl_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    spi_slave_regif #(.ADDR_WIDTH(7), .SYNC_STAGES(SYNC_STAGES)) dut (
        .SPI_CLK        (SPI_CLK),
        .SPI_CLK_RESET_N(SPI_CLK_RESET_N),
        .SCLK           (SCLK),
        .SCSN           (SCSN),
        .MOSI           (MOSI),
        .MISO           (MISO),
        .MISO_OE        (MISO_OE),
        .ADDR           (ADDR),
        .WR_STB         (WR_STB),
        .WR_DATA        (WR_DATA),
        .RD_REQ         (RD_REQ),
        .RD_DATA        (RD_DATA),
        .FRAME_ACTIVE   (FRAME_ACTIVE)
    );

    always #5 SPI_CLK = ~SPI_CLK;

    assign RD_DATA = rd_mem[ADDR];

    // Log strobes away from the active edge.
    always @(negedge SPI_CLK) begin
        if (WR_STB) wr_log.push_back({ADDR, WR_DATA});
        if (RD_REQ) rd_log.push_back(ADDR);
        if (WR_STB && RD_REQ) excl_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge SPI_CLK);
        #1;
    endtask

    // Send the top nbits of b MSB first, sampling MISO at each SCLK rise.
    task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = b[i];
            cyc(HALF);
            r[i] = MISO;
            SCLK = 1'b1;
            cyc(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic run_frame();
        logic [7:0] r;
        wr_log.delete();
        rd_log.delete();
        rx_q.delete();
        SCSN = 1'b0;
        cyc(HALF);
        foreach (tx_q[k]) begin
            send_byte(tx_q[k], 8, r);
            rx_q.push_back(r);
        end
        cyc(HALF);
        SCSN = 1'b1;
        cyc(HALF + 2);
    endtask

    // Reference: a write of n bytes gives n strobes at consecutive addresses (mod 128).
    // A read of n bytes gives n+1 requests, and the host receives rd_mem at consecutive addresses.
    task automatic check_frame();
        logic [7:0] cmd;
        int start, n;
        cmd   = tx_q[0];
        start = int'(cmd[6:0]);
        n     = tx_q.size() - 1;
        if (cmd[7]) begin
            check("wr_count", wr_log.size(), n);
            check("wr_no_rd", rd_log.size(), 0);
            for (int i = 0; i < n && i < wr_log.size(); i++) begin
                check("wr_addr", wr_log[i][14:8], (start + i) % 128);
                check("wr_data", wr_log[i][7:0], tx_q[i+1]);
            end
        end else begin
            check("rd_count", rd_log.size(), n + 1);
            check("rd_no_wr", wr_log.size(), 0);
            for (int i = 0; i <= n && i < rd_log.size(); i++)
                check("rd_addr", rd_log[i], (start + i) % 128);
            for (int i = 0; i < n; i++)
                check("miso_byte", rx_q[i+1], rd_mem[(start + i) % 128]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},    MISO, 0);
        check({tag, "_oe"},      MISO_OE, 0);
        check({tag, "_addr"},    ADDR, 0);
        check({tag, "_wr_stb"},  WR_STB, 0);
        check({tag, "_wr_data"}, WR_DATA, 0);
        check({tag, "_rd_req"},  RD_REQ, 0);
        check({tag, "_active"},  FRAME_ACTIVE, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int n;
        for (int i = 0; i < 128; i++) rd_mem[i] = 8'($urandom_range(0, 255));
        rd_mem[8'h10] = 8'h3C;
        rd_mem[8'h11] = 8'hC3;
        SPI_CLK_RESET_N = 1'b0;
        SCLK = 1'b0;
        SCSN = 1'b1;
        MOSI = 1'b0;
        cyc(3);
        check_reset_outputs("reset");
        SPI_CLK_RESET_N = 1'b1;
        cyc(HALF);

        // Single write.
        tx_q = '{8'h85, 8'hA5};
        run_frame();
        check_frame();

        // Burst write with address wrap.
        tx_q = '{8'hFF, 8'h11, 8'h22};
        run_frame();
        check_frame();

        // Read burst.
        tx_q = '{8'h10, 8'h00, 8'h00};
        run_frame();
        check_frame();

        // Abort inside a data byte: no strobe, and MISO_OE drops after the sync latency.
        wr_log.delete();
        rd_log.delete();
        SCSN = 1'b0;
        cyc(HALF);
        send_byte(8'h82, 8, r);
        send_byte(8'hFF, 5, r);
        cyc(HALF);
        SCSN = 1'b1;
        cyc(SYNC_STAGES);
        check("abort_oe_before", MISO_OE, 1);
        cyc(1);
        check("abort_oe_after", MISO_OE, 0);
        check("abort_miso", MISO, 0);
        cyc(HALF);
        check("abort_no_wr", wr_log.size(), 0);
        tx_q = '{8'h82, 8'h01};
        run_frame();
        check_frame();

        // Asynchronous reset during bit 4 of a write data byte.
        wr_log.delete();
        SCSN = 1'b0;
        cyc(HALF);
        send_byte(8'h83, 8, r);
        send_byte(8'hA0, 3, r);
        MOSI = 1'b0;
        cyc(HALF);
        SCLK = 1'b1;
        cyc(2);
        #2 SPI_CLK_RESET_N = 1'b0;
        #1 check_reset_outputs("midrst");
        SCLK = 1'b0;
        SCSN = 1'b1;
        cyc(3);
        SPI_CLK_RESET_N = 1'b1;
        cyc(HALF);
        check("midrst_no_wr", wr_log.size(), 0);
        tx_q = '{8'h90, 8'h5A};
        run_frame();
        check_frame();

        // Random write frames at minimum SCLK timing.
        for (int f = 0; f < 16; f++) begin
            tx_q.delete();
            tx_q.push_back({1'b1, 7'($urandom_range(0, 127))});
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) tx_q.push_back(8'($urandom_range(0, 255)));
            run_frame();
            check_frame();
        end

        // Random read frames.
        for (int f = 0; f < 4; f++) begin
            tx_q.delete();
            tx_q.push_back({1'b0, 7'($urandom_range(0, 127))});
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++) tx_q.push_back(8'($urandom_range(0, 255)));
            run_frame();
            check_frame();
        end

        check("strobe_excl", excl_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
